// File: rtl/mul_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_unit_pkg
// Shared definitions for the iterative shift-add multiplier.
//   MUL_WIDTH   : operand / result width (32)
//   mul_state_e : FSM state encodings MUL_IDLE / MUL_BUSY / MUL_DONE (2-bit)
// ---------------------------------------------------------------------------
package mul_unit_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage : mul_unit_pkg

// File: rtl/mul_unit_step.sv
// ---------------------------------------------------------------------------
// mul_unit_step
// Combinational single step of the shift-add multiplier.
//   acc, mcand, mplier                : current accumulator, multiplicand,
//                                       multiplier
//   acc_next, mcand_next, mplier_next : values after one step
// The accumulator adds the (already shifted) multiplicand when the current
// multiplier LSB is set; the sum is truncated to WIDTH bits.
// ---------------------------------------------------------------------------
module mul_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0] mplier_next
);

    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
    end

endmodule : mul_unit_step

// File: rtl/mul_unit.sv
// ---------------------------------------------------------------------------
// mul_unit
// Iterative 32-bit shift-add multiplier for the execute stage (ALU_MUL).
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-low reset
//   start_i     : launch request, sampled only in IDLE or DONE
//   flush_i     : synchronous abort, returns to IDLE, has priority over start
//   data1_i     : multiplicand (rs1), sampled on the start edge only
//   data2_i     : multiplier (rs2), sampled on the start edge only
//   data_o      : low WIDTH bits of the last completed product
//   valid_o     : one-cycle strobe, high while in DONE
//   busy_o      : high while in BUSY; stalls PC and register-file write
//   dbg_state_o : current FSM state (debug visibility)
//
// Handshake: a start accepted at edge 0 gives busy_o high after edges
// 0..WIDTH-1 and valid_o high for the single cycle after edge WIDTH.
// data_o changes only when a multiply completes (or on reset) and is held
// otherwise. start_i held high in DONE begins the next multiply with no
// idle cycle in between.
// ---------------------------------------------------------------------------
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic [1:0]       dbg_state_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_e       state_q;
    mul_state_e       state_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mcand_next;
    logic [WIDTH-1:0] mplier_next;

    logic             accept;
    logic             last_step;

    mul_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc         (acc_q),
        .mcand       (mcand_q),
        .mplier      (mplier_q),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    // A start is only honoured outside BUSY, and never in a flush cycle.
    assign accept    = (state_q != MUL_BUSY) && start_i && !flush_i;
    assign last_step = (state_q == MUL_BUSY) && (cnt_q == CNT_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start_i) state_d = MUL_BUSY;
            MUL_BUSY: if (cnt_q == CNT_LAST) state_d = MUL_DONE;
            MUL_DONE: state_d = start_i ? MUL_BUSY : MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
        if (flush_i) begin
            state_d = MUL_IDLE;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
        end else if (accept) begin
            mcand_q  <= data1_i;
            mplier_q <= data2_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if ((state_q == MUL_BUSY) && !flush_i) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_next;
            mplier_q <= mplier_next;
            cnt_q    <= cnt_q + CNT_W'(1);
            // The result includes the contribution of the final step.
            if (last_step) begin
                data_q <= acc_next;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = (state_q == MUL_DONE);
    assign busy_o      = (state_q == MUL_BUSY);
    assign dbg_state_o = state_q;

endmodule : mul_unit

// File: tb/tb_mul_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_unit
// Directed self-checking bench for mul_unit. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_mul_unit;

    localparam int W = 32;

    logic         clk_i;
    logic         rst_i;
    logic         start_i;
    logic         flush_i;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         busy_o;
    logic [1:0]   dbg_state_o;

    int n_checks;
    int n_fail;

    logic [W-1:0] exp_q[$];

    mul_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .flush_i     (flush_i),
        .data1_i     (data1_i),
        .data2_i     (data2_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drive a start for one edge; afterwards the DUT should be in its first BUSY cycle.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp_v);
        start_i = 1'b1;
        data1_i = a;
        data2_i = b;
        exp_q.push_back(exp_v);
        step();
        start_i = 1'b0;
    endtask

    // Follows a multiply from its first BUSY cycle through the DONE cycle.
    // inj_at > 0 pulses start_i (9 x 9) on that BUSY edge; it must be ignored.
    task automatic track(input string tag, input int inj_at);
        logic [W-1:0] e;
        int bad;
        bad = 0;
        if (exp_q.size() == 0) begin
            e = '0;
            check($sformatf("%s_queue_empty", tag), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
        end
        check($sformatf("%s_busy_first", tag), {31'b0, busy_o}, 32'd1);
        for (int i = 1; i <= W - 1; i++) begin
            if (i == inj_at) begin
                start_i = 1'b1;
                data1_i = 32'd9;
                data2_i = 32'd9;
            end
            step();
            start_i = 1'b0;
            data1_i = $urandom;
            data2_i = $urandom;
            if (!(busy_o === 1'b1 && valid_o === 1'b0)) bad++;
        end
        check($sformatf("%s_busy_window_errs", tag), bad, 32'd0);
        step();
        check($sformatf("%s_valid", tag), {31'b0, valid_o}, 32'd1);
        check($sformatf("%s_busy_done", tag), {31'b0, busy_o}, 32'd0);
        check($sformatf("%s_state_done", tag), {30'b0, dbg_state_o}, 32'd2);
        check($sformatf("%s_data", tag), data_o, e);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int vbad;
        n_checks = 0;
        n_fail   = 0;
        rst_i    = 1'b0;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        data1_i  = '0;
        data2_i  = '0;

        // Reset state
        #2;
        check("rst_data", data_o, 32'd0);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_state", {30'b0, dbg_state_o}, 32'd0);
        step();
        rst_i = 1'b1;
        step();
        check("idle_hold", {30'b0, dbg_state_o}, 32'd0);

        // Basic multiply
        launch(32'd3, 32'd5, 32'h0000000F);
        track("basic", 0);
        step();
        check("basic_valid_drop", {31'b0, valid_o}, 32'd0);
        check("basic_idle", {30'b0, dbg_state_o}, 32'd0);
        check("basic_data_hold", data_o, 32'h0000000F);

        // Truncation
        launch(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
        track("trunc_a", 0);
        step();
        launch(32'h00010000, 32'h00010000, 32'h00000000);
        track("trunc_b", 0);
        step();

        // Signed operands: -7 x 6 = -42
        launch(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6);
        track("signed", 0);
        step();

        // Start while busy is ignored; start held in DONE restarts immediately
        launch(32'd4, 32'd4, 32'h00000010);
        track("busy_start", 10);
        start_i = 1'b1;
        data1_i = 32'd2;
        data2_i = 32'd7;
        exp_q.push_back(32'd14);
        step();
        start_i = 1'b0;
        track("back2back", 0);
        step();

        // Flush at cycle 20 of 7 x 7
        launch(32'd7, 32'd7, 32'd49);
        for (int i = 1; i < 20; i++) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_state", {30'b0, dbg_state_o}, 32'd0);
        check("flush_busy", {31'b0, busy_o}, 32'd0);
        vbad = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o !== 1'b0) vbad++;
            step();
        end
        check("flush_no_valid", vbad, 32'd0);
        check("flush_data_kept", data_o, 32'd14);
        void'(exp_q.pop_back());

        // Flush has priority over start
        start_i = 1'b1;
        flush_i = 1'b1;
        data1_i = 32'd5;
        data2_i = 32'd5;
        step();
        start_i = 1'b0;
        flush_i = 1'b0;
        check("flush_prio_state", {30'b0, dbg_state_o}, 32'd0);
        check("flush_prio_busy", {31'b0, busy_o}, 32'd0);
        step();

        // Reset mid-operation, asynchronous
        launch(32'd8, 32'd8, 32'd64);
        for (int i = 1; i < 15; i++) step();
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_data", data_o, 32'd0);
        check("arst_busy", {31'b0, busy_o}, 32'd0);
        check("arst_valid", {31'b0, valid_o}, 32'd0);
        void'(exp_q.pop_back());
        step();
        rst_i = 1'b1;
        step();
        check("arst_idle", {30'b0, dbg_state_o}, 32'd0);
        launch(32'd2, 32'd3, 32'd6);
        track("after_rst", 0);
        step();
        check("after_rst_valid_drop", {31'b0, valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mul_unit
